// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : PC register and fetch control for the word-addressed instruction
//            memory (BOOT/RUN/HALT sequencing, redirect, stall, fault capture).
//            Optional FETCH_COUNT_EN adds a saturating fetch_count output.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
    parameter int                    MEM_CAPACITY = 10,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  pc_src,
    input  logic [DATA_WIDTH-1:0] pc_target,
    input  logic                  halt_req,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  imem_en,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic                  halted,
`ifdef FETCH_COUNT_EN
    output logic [1:0]            fault,
    output logic [CNT_WIDTH-1:0]  fetch_count
`else
    output logic [1:0]            fault
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0]            c_fault_none  = 2'b00;
    localparam logic [1:0]            c_fault_align = 2'b01;
    localparam logic [1:0]            c_fault_range = 2'b10;
    localparam logic [1:0]            c_fault_halt  = 2'b11;
    localparam logic [DATA_WIDTH-1:0] c_mem_cap     = DATA_WIDTH'(MEM_CAPACITY);
    localparam logic [DATA_WIDTH-1:0] c_four        = DATA_WIDTH'(4);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be 4-byte aligned");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [1:0]            r_fault;
    logic [1:0]            w_fault_nxt;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_cand;
    logic                  w_fetch_adv;

    assign w_pc_plus4 = r_pc + c_four;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_fault <= c_fault_none;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Priority: halt request, misaligned redirect, stall, redirect, sequential.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        w_fetch_adv = 1'b0;
        w_cand      = pc_src ? pc_target : w_pc_plus4;
        if (en) begin
            case (r_state)
                ST_BOOT: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (halt_req) begin
                        w_state_nxt = ST_HALT;
                        w_fault_nxt = c_fault_halt;
                    end else if (pc_src && (pc_target[1:0] != 2'b00)) begin
                        w_state_nxt = ST_HALT;
                        w_fault_nxt = c_fault_align;
                    end else if (!stall) begin
                        // Out-of-range PC is still loaded so software can inspect it.
                        w_pc_nxt = w_cand;
                        if ((w_cand >> 2) >= c_mem_cap) begin
                            w_state_nxt = ST_HALT;
                            w_fault_nxt = c_fault_range;
                        end else begin
                            w_fetch_adv = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign imem_addr = r_pc >> 2;
    assign imem_en   = (r_state == ST_RUN) && en && !stall;
    assign halted    = (r_state == ST_HALT);
    assign fault     = r_fault;

`ifdef FETCH_COUNT_EN
    logic [CNT_WIDTH-1:0] r_fetch_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_count <= '0;
        end else if (w_fetch_adv && (r_fetch_count != {CNT_WIDTH{1'b1}})) begin
            r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    logic w_unused_adv;
    assign w_unused_adv = w_fetch_adv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit; expected PC/halt/fault
//            tuples are queued when stimulus is applied and popped after edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic        halted;
    logic [1:0]  fault;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [66:0] sb[$];
    logic [66:0] exp_v;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .DATA_WIDTH  (32),
        .RESET_PC    (32'h0),
        .MEM_CAPACITY(10),
        .CNT_WIDTH   (32)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .stall      (stall),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .halt_req   (halt_req),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .halted     (halted),
`ifdef FETCH_COUNT_EN
        .fault      (fault),
        .fetch_count(fetch_count)
`else
        .fault      (fault)
`endif
    );

    // Expected tuple {pc, word address, halted, fault}; the address is pc/4.
    function automatic logic [66:0] exp_of(input logic [31:0] p, input logic h, input logic [1:0] f);
        logic [31:0] a;
        a = p / 32'd4;
        return {p, a, h, f};
    endfunction

    function automatic logic [66:0] obs();
        return {pc, imem_addr, halted, fault};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; stall = 1'b0; pc_src = 1'b0;
        pc_target = 32'h0; halt_req = 1'b0;
        #3;
        n_cmp++;
        if ({pc, imem_addr, pc_plus4, imem_en, halted, fault} !== {32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_values: got pc=%h addr=%h p4=%h en=%b h=%b f=%b want 0/0/4/0/0/00",
                     pc, imem_addr, pc_plus4, imem_en, halted, fault);
        end
`ifdef FETCH_COUNT_EN
        n_cmp++;
        if (fetch_count !== 32'd0) begin
            n_bad++; $display("FAIL reset_count: got %0d want 0", fetch_count);
        end
`endif
        @(negedge clk);
        rstn = 1'b1; en = 1'b1;
    endtask

    task automatic test_sequential();
        n_cmp++;
        if (imem_en !== 1'b0) begin
            n_bad++; $display("FAIL boot_imem_en: got %b want 0", imem_en);
        end
        sb.push_back(exp_of(32'h0, 1'b0, 2'b00));
        for (int k = 1; k <= 3; k++) sb.push_back(exp_of(32'(4 * k), 1'b0, 2'b00));
        for (int k = 0; k <= 3; k++) begin
            cyc();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL seq_step%0d: got %h want %h", k, obs(), exp_v);
            end
            n_cmp++;
            if (imem_en !== 1'b1) begin
                n_bad++; $display("FAIL seq_imem_en%0d: got %b want 1", k, imem_en);
            end
        end
    endtask

    task automatic test_redirect();
        pc_src = 1'b1; pc_target = 32'h4;
        sb.push_back(exp_of(32'h4, 1'b0, 2'b00));
        cyc();
        pc_src = 1'b0;
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs() !== exp_v) begin
            n_bad++; $display("FAIL redirect: got %h want %h", obs(), exp_v);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; pc_src = 1'b1; pc_target = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (imem_en !== 1'b0) begin
                n_bad++; $display("FAIL stall_imem_en%0d: got %b want 0", k, imem_en);
            end
            sb.push_back(exp_of(32'h4, 1'b0, 2'b00));
            cyc();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL stall_hold%0d: got %h want %h", k, obs(), exp_v);
            end
        end
        stall = 1'b0; pc_src = 1'b0;
        sb.push_back(exp_of(32'h8, 1'b0, 2'b00));
        sb.push_back(exp_of(32'hC, 1'b0, 2'b00));
        for (int k = 0; k < 2; k++) begin
            cyc();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL stall_resume%0d: got %h want %h", k, obs(), exp_v);
            end
        end
`ifdef FETCH_COUNT_EN
        n_cmp++;
        if (fetch_count !== 32'd6) begin
            n_bad++; $display("FAIL stall_count: got %0d want 6", fetch_count);
        end
`endif
    endtask

    task automatic test_enable();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) en = 1'b1;
            #1;
            n_cmp++;
            if (imem_en !== (k == 2)) begin
                n_bad++; $display("FAIL enable_imem_en%0d: got %b want %b", k, imem_en, (k == 2));
            end
            sb.push_back(exp_of((k == 2) ? 32'h10 : 32'hC, 1'b0, 2'b00));
            cyc();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL enable_step%0d: got %h want %h", k, obs(), exp_v);
            end
        end
`ifdef FETCH_COUNT_EN
        n_cmp++;
        if (fetch_count !== 32'd7) begin
            n_bad++; $display("FAIL enable_count: got %0d want 7", fetch_count);
        end
`endif
    endtask

    task automatic test_misaligned();
        pc_src = 1'b1; pc_target = 32'h6;
        for (int k = 0; k < 4; k++) sb.push_back(exp_of(32'h10, 1'b1, 2'b01));
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 0) begin
                halt_req = 1'b1; pc_target = 32'h0; stall = 1'b0;
            end
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL misaligned%0d: got %h want %h", k, obs(), exp_v);
            end
        end
        #1;
        n_cmp++;
        if ({imem_en, pc_plus4} !== {1'b0, 32'h14}) begin
            n_bad++; $display("FAIL misaligned_outs: got en=%b p4=%h want 0/14", imem_en, pc_plus4);
        end
    endtask

    task automatic test_range();
        sb.push_back(exp_of(32'h0, 1'b0, 2'b00));
        for (int k = 1; k <= 9; k++) sb.push_back(exp_of(32'(4 * k), 1'b0, 2'b00));
        sb.push_back(exp_of(32'h28, 1'b1, 2'b10));
        sb.push_back(exp_of(32'h28, 1'b1, 2'b10));
        for (int k = 0; k <= 11; k++) begin
            cyc();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL range_step%0d: got %h want %h", k, obs(), exp_v);
            end
        end
        n_cmp++;
        if (imem_en !== 1'b0) begin
            n_bad++; $display("FAIL range_imem_en: got %b want 0", imem_en);
        end
`ifdef FETCH_COUNT_EN
        n_cmp++;
        if (fetch_count !== 32'd9) begin
            n_bad++; $display("FAIL range_count: got %0d want 9", fetch_count);
        end
`endif
    endtask

    task automatic test_wrap();
        sb.push_back(exp_of(32'h0, 1'b0, 2'b00));
        sb.push_back(exp_of(32'hFFFF_FFFC, 1'b1, 2'b10));
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
            end
            cyc();
            pc_src = 1'b0;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL wrap_step%0d: got %h want %h", k, obs(), exp_v);
            end
        end
        n_cmp++;
        if (pc_plus4 !== 32'h0) begin
            n_bad++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4);
        end
    endtask

    task automatic test_halt_priority();
        sb.push_back(exp_of(32'h0, 1'b0, 2'b00));
        sb.push_back(exp_of(32'h4, 1'b0, 2'b00));
        sb.push_back(exp_of(32'h4, 1'b1, 2'b11));
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                halt_req = 1'b1; pc_src = 1'b1; pc_target = 32'h6;
            end
            cyc();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL halt_prio%0d: got %h want %h", k, obs(), exp_v);
            end
        end
        halt_req = 1'b0; pc_src = 1'b0;
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if ({pc, imem_en, halted, fault} !== {32'h0, 1'b0, 1'b0, 2'b00}) begin
            n_bad++; $display("FAIL async_reset: got pc=%h en=%b h=%b f=%b want 0/0/0/00",
                              pc, imem_en, halted, fault);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (imem_en !== 1'b0) begin
            n_bad++; $display("FAIL reboot_imem_en: got %b want 0", imem_en);
        end
        sb.push_back(exp_of(32'h0, 1'b0, 2'b00));
        sb.push_back(exp_of(32'h4, 1'b0, 2'b00));
        for (int k = 0; k < 2; k++) begin
            cyc();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs() !== exp_v || imem_en !== 1'b1) begin
                n_bad++; $display("FAIL reboot_step%0d: got %h en=%b want %h en=1", k, obs(), imem_en, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_enable();
        test_misaligned();
        test_reset();
        test_range();
        test_reset();
        test_wrap();
        test_reset();
        test_halt_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
